// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Combinational 1-bit full adder made of two half-adder stages and an OR.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic h1_s;
  logic h1_c;
  logic h2_c;

  assign h1_s = a ^ b;
  assign h1_c = a & b;
  assign s    = h1_s ^ ci;
  assign h2_c = h1_s & ci;
  assign co   = h1_c | h2_c;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell reused LSB-first over WIDTH cycles,
// with registered result outputs that only change on entry to DONE.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] psum_q;
  logic [WIDTH-1:0] psum_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;
  logic             fa_s;
  logic             fa_co;

  fa_cell u_fa (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 is in place.
  assign psum_d = {fa_s, psum_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      psum_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sr_q  <= a;
            b_sr_q  <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            psum_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_sr_q  <= a_sr_q >> 1;
          b_sr_q  <= b_sr_q >> 1;
          carry_q <= fa_co;
          psum_q  <= psum_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            // carry_q is still the carry into the MSB on this cycle.
            sum_q   <= psum_d;
            cout_q  <= fa_co;
            ovf_q   <= carry_q ^ fa_co;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed vectors, corner sequences and a reference-model random run for serial_add_ctrl.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_tests;
  int n_fail;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
  } op_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 one cycle after the done pulse.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        input logic [W-1:0] es, input logic ec, input logic eo);
    int cyc;
    start = 1'b1; a = av; b = bv; cin = cv;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    chk("busy_after_accept", 32'(busy), 32'd1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", cyc, W);
    chk("sum", 32'(sum), 32'(es));
    chk("cout", 32'(cout), 32'(ec));
    chk("ovf", 32'(ovf), 32'(eo));
    chk("busy_in_done", 32'(busy), 32'd1);
    $display("[TB] op a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d ovf=%0d latency=%0d",
             av, bv, cv, sum, cout, ovf, cyc);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_cleared", 32'(busy), 32'd0);
    chk("sum_hold", 32'(sum), 32'(es));
  endtask

  vec_t vecs[8];

  initial begin
    int   dones;
    int   cycles;
    int   ops_acc;
    int   ops_chk;
    int   m_st;
    int   m_cnt;
    int   last_done_cyc;
    op_t  q[$];
    op_t  o;
    logic [W:0] full;
    logic       eovf;

    n_tests = 0;
    n_fail  = 0;

    vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};

    reset = 1'b1; start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    start = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].ovf);

    // start pulses during RUN and during DONE must be ignored
    start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    for (int i = 1; i <= 24; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
      if (i == 8) chk("ignore_done_at_8", 32'(done), 32'd1);
      start = (i == 3 || i == 8) ? 1'b1 : 1'b0;
      a = 8'hFF; b = 8'hFF; cin = 1'b1;
    end
    start = 1'b0;
    chk("ignore_single_done", dones, 1);
    chk("ignore_sum", 32'(sum), 32'h46);
    chk("ignore_cout", 32'(cout), 32'd0);
    chk("ignore_busy", 32'(busy), 32'd0);
    $display("[TB] busy-ignore: dones=%0d sum=%02h cout=%0d", dones, sum, cout);

    // asynchronous reset in the middle of RUN
    start = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrun_rst_busy", 32'(busy), 32'd0);
    chk("midrun_rst_done", 32'(done), 32'd0);
    chk("midrun_rst_sum", 32'(sum), 32'd0);
    chk("midrun_rst_cout", 32'(cout), 32'd0);
    chk("midrun_rst_ovf", 32'(ovf), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    chk("midrun_no_done", dones, 0);
    $display("[TB] mid-run reset: dones after reset=%0d", dones);
    run_op(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);

    // random run: first 600 ops with start held high, the rest with random start
    m_st = 0; m_cnt = 0; ops_acc = 0; ops_chk = 0; cycles = 0; last_done_cyc = -1;
    while (ops_chk < 1000 && cycles < 20000) begin
      start = (ops_acc < 600) ? 1'b1 : (($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      @(posedge clk);
      cycles++;
      case (m_st)
        0: if (start) begin
             q.push_back('{a, b, cin});
             ops_acc++;
             m_cnt = 0;
             m_st = 1;
           end
        1: begin
             m_cnt++;
             if (m_cnt == W) m_st = 2;
           end
        default: m_st = 0;
      endcase
      #1;
      chk("rand_done_timing", 32'(done), (m_st == 2) ? 32'd1 : 32'd0);
      if (m_st == 2 && q.size() > 0) begin
        o = q.pop_front();
        ops_chk++;
        full = {1'b0, o.a} + {1'b0, o.b} + (W+1)'(o.cin);
        eovf = (o.a[W-1] == o.b[W-1]) && (full[W-1] != o.a[W-1]);
        chk("rand_sum", 32'(sum), 32'(full[W-1:0]));
        chk("rand_cout", 32'(cout), 32'(full[W]));
        chk("rand_ovf", 32'(ovf), 32'(eovf));
        if (ops_chk >= 2 && ops_chk <= 600)
          chk("rand_spacing", cycles - last_done_cyc, W + 2);
        last_done_cyc = cycles;
      end
    end
    start = 1'b0;
    chk("rand_ops_completed", ops_chk, 1000);
    $display("[TB] random: %0d ops checked in %0d cycles", ops_chk, cycles);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
